// File: rtl/flick_conditioner.sv
// flick_conditioner: synchronises and debounces the raw push-button input
// that feeds bound_flasher. Produces a clean registered level `flick`,
// one-cycle edge pulses, and a saturating count of rejected bounces.
module flick_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flick_raw,
  output logic                flick,
  output logic                flick_rise,
  output logic                flick_fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    LOW_CHK  = 2'd1,
    HIGH     = 2'd2,
    HIGH_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};
  localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   glitch_hit;

  logic                   flick_next;
  logic                   rise_next;
  logic                   fall_next;

  // Plain flop chain bringing the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], flick_raw};
    end
  end

  assign sync_q = sync_chain[SYNC_STAGES-1];

  // State and debounce counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOW;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: a candidate level must persist DEBOUNCE_CYCLES samples
  // before it is accepted; any reversion during the check counts as a glitch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    glitch_hit = 1'b0;
    case (state)
      LOW: begin
        if (sync_q) begin
          state_next = LOW_CHK;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = CNT_ZERO;
        end
      end
      LOW_CHK: begin
        if (!sync_q) begin
          state_next = LOW;
          cnt_next   = CNT_ZERO;
          glitch_hit = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_next = HIGH;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next   = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!sync_q) begin
          state_next = HIGH_CHK;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = CNT_ZERO;
        end
      end
      HIGH_CHK: begin
        if (sync_q) begin
          state_next = HIGH;
          cnt_next   = CNT_ZERO;
          glitch_hit = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_next = LOW;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the first cycle of the new level.
  always_comb begin
    flick_next = 1'b0;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if ((state_next == HIGH) || (state_next == HIGH_CHK)) begin
      flick_next = 1'b1;
    end else begin
      flick_next = 1'b0;
    end
    if ((state == LOW_CHK) && (state_next == HIGH)) begin
      rise_next = 1'b1;
    end else begin
      rise_next = 1'b0;
    end
    if ((state == HIGH_CHK) && (state_next == LOW)) begin
      fall_next = 1'b1;
    end else begin
      fall_next = 1'b0;
    end
  end

  // Registered level and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flick      <= 1'b0;
      flick_rise <= 1'b0;
      flick_fall <= 1'b0;
    end else begin
      flick      <= flick_next;
      flick_rise <= rise_next;
      flick_fall <= fall_next;
    end
  end

  // Saturating glitch counter, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= {GLITCH_W{1'b0}};
    end else if (glitch_hit && (glitch_cnt != GLITCH_MAX)) begin
      glitch_cnt <= glitch_cnt + GLITCH_ONE;
    end else begin
      glitch_cnt <= glitch_cnt;
    end
  end

endmodule

// File: tb/tb_flick_conditioner.sv
// Directed self-checking bench for flick_conditioner (default parameters),
// plus a second instance with GLITCH_W=2 for glitch counter saturation.
module tb_flick_conditioner;

  logic       clk;
  logic       rst_n;
  logic       flick_raw;
  logic       flick;
  logic       flick_rise;
  logic       flick_fall;
  logic [7:0] glitch_cnt;

  logic       raw_s;
  logic       flick_s;
  logic       rise_s;
  logic       fall_s;
  logic [1:0] glitch_s;

  int n_checks = 0;
  int n_fail   = 0;

  flick_conditioner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flick_raw  (flick_raw),
    .flick      (flick),
    .flick_rise (flick_rise),
    .flick_fall (flick_fall),
    .glitch_cnt (glitch_cnt)
  );

  flick_conditioner #(.GLITCH_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .flick_raw  (raw_s),
    .flick      (flick_s),
    .flick_rise (rise_s),
    .flick_fall (fall_s),
    .glitch_cnt (glitch_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // advance past one rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic f, input logic r, input logic fl);
    chk_eq({tag, "_flick"}, {31'd0, flick}, {31'd0, f});
    chk_eq({tag, "_rise"},  {31'd0, flick_rise}, {31'd0, r});
    chk_eq({tag, "_fall"},  {31'd0, flick_fall}, {31'd0, fl});
  endtask

  initial begin
    rst_n     = 1'b0;
    flick_raw = 1'b0;
    raw_s     = 1'b0;
    #12;
    chk_outs("reset", 1'b0, 1'b0, 1'b0);
    chk_eq("reset_glitch", {24'd0, glitch_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_outs("idle", 1'b0, 1'b0, 1'b0);

    // 1. clean press: flick goes high 5 edges after E0 (first tick below)
    flick_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_outs($sformatf("press_%0d", i), (i >= 6), (i == 6), 1'b0);
    end
    chk_eq("press_glitch", {24'd0, glitch_cnt}, 32'd0);

    // 4. release: symmetric 5-edge latency, single fall pulse
    flick_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_outs($sformatf("release_%0d", i), (i < 6), 1'b0, (i == 6));
    end

    // 2. single-cycle glitch
    flick_raw = 1'b1;
    tick();
    flick_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_outs($sformatf("glitch_%0d", i), 1'b0, 1'b0, 1'b0);
    end
    chk_eq("glitch_cnt1", {24'd0, glitch_cnt}, 32'd1);

    // 3. bouncy press 1,0,1,0,1 then held; final rise sampled at E0+4
    for (int i = 0; i < 20; i++) begin
      flick_raw = (i >= 4) ? 1'b1 : ((i % 2) == 0);
      tick();
      chk_outs($sformatf("bounce_%0d", i), (i >= 9), (i == 9), 1'b0);
    end
    chk_eq("bounce_glitch", {24'd0, glitch_cnt}, 32'd3);

    // 5. reset mid-press with input held high
    rst_n = 1'b0;
    #1;
    chk_outs("rstmid_now", 1'b0, 1'b0, 1'b0);
    chk_eq("rstmid_glitch", {24'd0, glitch_cnt}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_outs($sformatf("rstmid_hold_%0d", i), 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_outs($sformatf("rerise_%0d", i), (i >= 6), (i == 6), 1'b0);
    end
    chk_eq("rerise_glitch", {24'd0, glitch_cnt}, 32'd0);

    // 6. saturation on the GLITCH_W=2 instance
    for (int k = 1; k <= 5; k++) begin
      raw_s = 1'b1;
      tick();
      raw_s = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk_eq($sformatf("sat_glitch_%0d", k), {30'd0, glitch_s}, (k >= 3) ? 32'd3 : k);
      chk_eq($sformatf("sat_flick_%0d", k), {31'd0, flick_s}, 32'd0);
    end
    for (int i = 0; i < 10; i++) tick();
    chk_eq("sat_hold", {30'd0, glitch_s}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
